// File: rtl/even_down_counter.sv
// -----------------------------------------------------------------------------
// even_down_counter
//
// Synchronous even down-counter. Steps by 2 from TOP = 2^WIDTH - 2 toward 0,
// with enable, parallel load, a registered terminal-count pulse and an
// optional stop-at-zero mode. Companion of the even up-counter in the counter
// library: same clocking and reset style, opposite count direction.
//
// Parameters:
//   WIDTH    counter width in bits (minimum 2)
//   WRAP     1 = wrap from 0 back to TOP, 0 = stop and hold at 0
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset (q=TOP, tc=0, done=0)
//   en        in   1      count enable, decrements q by 2 per clock
//   load      in   1      parallel-load strobe (priority over en)
//   load_val  in   WIDTH  load value, bit 0 ignored
//   q         out  WIDTH  counter value, q[0] is always 0
//   zero      out  1      combinational, high when q == 0
//   tc        out  1      one-cycle pulse after q reaches 0 by counting
//   done      out  1      sticky stop-at-zero flag (always 0 when WRAP=1)
// -----------------------------------------------------------------------------
module even_down_counter #(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc,
    output logic             done
);

    // Only the counting bits [WIDTH-1:1] are state; q[0] is a constant 0.
    logic [WIDTH-1:1] r_cnt;
    logic             r_tc;
    logic             r_done;

    logic [WIDTH-1:1] w_borrow;
    logic [WIDTH-1:1] w_next;
    logic             w_at_zero;
    logic             w_next_zero;
    logic             w_unused_lsb;

    // Load value LSB is discarded by design.
    assign w_unused_lsb = load_val[0];

    // Ripple-borrow chain: bit i toggles when every lower counting bit is 0.
    // At q == 0 every bit toggles, which lands exactly on TOP (all ones).
    always_comb begin
        w_borrow    = '0;
        w_borrow[1] = 1'b1;
        for (int unsigned i = 2; i < WIDTH; i++) begin
            w_borrow[i] = w_borrow[i-1] & ~r_cnt[i-1];
        end
    end

    assign w_next      = r_cnt ^ w_borrow;
    assign w_at_zero   = (r_cnt == '0);
    assign w_next_zero = (w_next == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '1;
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else if (load) begin
            r_cnt  <= load_val[WIDTH-1:1];
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else if (en) begin
            r_tc <= 1'b0;
            if (w_at_zero) begin
                if (WRAP) begin
                    r_cnt <= w_next;
                end else begin
                    r_done <= 1'b1;
                end
            end else begin
                r_cnt <= w_next;
                r_tc  <= w_next_zero;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign q    = {r_cnt, 1'b0};
    assign zero = w_at_zero;
    assign tc   = r_tc;
    assign done = r_done;

endmodule

// File: tb/tb_even_down_counter.sv
module tb_even_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    logic [7:0] q_a, q_b;
    logic [3:0] q_c;
    logic       zero_a, zero_b, zero_c;
    logic       tc_a, tc_b, tc_c;
    logic       done_a, done_b, done_c;

    always #5 clk = ~clk;

    // a: WIDTH=8 wrap, b: WIDTH=8 stop-at-zero, c: WIDTH=4 wrap
    even_down_counter #(.WIDTH(8), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .q(q_a), .zero(zero_a), .tc(tc_a), .done(done_a)
    );
    even_down_counter #(.WIDTH(8), .WRAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .q(q_b), .zero(zero_b), .tc(tc_b), .done(done_b)
    );
    even_down_counter #(.WIDTH(4), .WRAP(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[3:0]),
        .q(q_c), .zero(zero_c), .tc(tc_c), .done(done_c)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       done;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, plain integers
    int m_q[3];
    int m_tc[3];
    int m_done[3];
    int m_w[3]    = '{8, 8, 4};
    int m_wrap[3] = '{1, 0, 1};

    task automatic model_step(input int k, input bit r, input bit l, input int lv, input bit e);
        int modulus;
        int top;
        modulus = 1 << m_w[k];
        top     = modulus - 2;
        if (r) begin
            m_q[k] = top; m_tc[k] = 0; m_done[k] = 0;
        end else if (l) begin
            m_q[k] = (lv % modulus) / 2 * 2; m_tc[k] = 0; m_done[k] = 0;
        end else if (e) begin
            if (m_q[k] == 0) begin
                m_tc[k] = 0;
                if (m_wrap[k] != 0) m_q[k] = top;
                else m_done[k] = 1;
            end else begin
                m_q[k]  = m_q[k] - 2;
                m_tc[k] = (m_q[k] == 0) ? 1 : 0;
            end
        end else begin
            m_tc[k] = 0;
        end
    endtask

    function automatic exp_t mk(input int k);
        exp_t x;
        x.q    = 8'(m_q[k]);
        x.tc   = (m_tc[k] != 0);
        x.done = (m_done[k] != 0);
        return x;
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge response
    task automatic cyc(input bit r, input bit l, input logic [7:0] lv, input bit e);
        @(negedge clk);
        reset = r; load = l; load_val = lv; en = e;
        for (int k = 0; k < 3; k++) model_step(k, r, l, int'(lv), e);
        sb_a.push_back(mk(0));
        sb_b.push_back(mk(1));
        sb_c.push_back(mk(2));
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle once a response is queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                chk("a.q",    q_a, e.q);
                chk("a.zero", {7'd0, zero_a}, {7'd0, e.q == 8'd0});
                chk("a.tc",   {7'd0, tc_a}, {7'd0, e.tc});
                chk("a.done", {7'd0, done_a}, {7'd0, e.done});
                chk("a.q0",   {7'd0, q_a[0]}, 8'd0);
            end
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                chk("b.q",    q_b, e.q);
                chk("b.zero", {7'd0, zero_b}, {7'd0, e.q == 8'd0});
                chk("b.tc",   {7'd0, tc_b}, {7'd0, e.tc});
                chk("b.done", {7'd0, done_b}, {7'd0, e.done});
                chk("b.q0",   {7'd0, q_b[0]}, 8'd0);
            end
            if (sb_c.size() > 0) begin
                e = sb_c.pop_front();
                chk("c.q",    {4'd0, q_c}, e.q);
                chk("c.zero", {7'd0, zero_c}, {7'd0, e.q == 8'd0});
                chk("c.tc",   {7'd0, tc_c}, {7'd0, e.tc});
                chk("c.done", {7'd0, done_c}, {7'd0, e.done});
            end
        end
    end

    initial begin
        // Reset then count
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        repeat (5) cyc(0, 0, 8'h00, 1);

        // Full wrap from reset: 128 enabled cycles plus a couple more
        cyc(1, 0, 8'h00, 0);
        repeat (130) cyc(0, 0, 8'h00, 1);

        // Odd load with en high: load wins, bit 0 dropped
        cyc(0, 1, 8'h07, 1);
        repeat (6) cyc(0, 0, 8'h00, 1);

        // Stop mode behaviour (instance b), then load clears done
        cyc(0, 1, 8'h04, 1);
        repeat (13) cyc(0, 0, 8'h00, 1);
        cyc(0, 1, 8'h10, 1);
        cyc(0, 0, 8'h00, 0);

        // Enable gating at 3A
        cyc(0, 1, 8'h3C, 0);
        cyc(0, 0, 8'h00, 1);
        repeat (7) cyc(0, 0, 8'h00, 0);
        repeat (3) cyc(0, 0, 8'h00, 1);

        // Reset with load and en while tc is high
        cyc(0, 1, 8'h02, 0);
        cyc(0, 0, 8'h00, 1);
        cyc(1, 1, 8'h22, 1);
        cyc(0, 0, 8'h00, 0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                8'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 10 && sb_a.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        chk("drain", 8'(sb_a.size() + sb_b.size() + sb_c.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
